// File: rtl/imem_fetch_buffer.sv
// Byte-serial instruction loader feeding the SEQ fetch stage: reads one byte per cycle
// until the icode-implied length is captured. Optional macro: IMEM_BOUND_CHECK_EN.
module imem_fetch_buffer #(
    parameter int IMEM_AW   = 10,
    parameter int IMEM_SIZE = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [63:0]        req_pc,
    output logic               imem_rd,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [7:0]         imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:79]        instruct,
    output logic [63:0]        out_pc,
    output logic [3:0]         out_len,
    output logic               mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    if (IMEM_SIZE > (2 ** IMEM_AW)) begin : g_bad_size
        $error("IMEM_SIZE exceeds the range addressable by IMEM_AW");
    end

    function automatic logic [3:0] decode_len(input logic [3:0] icode);
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd1;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [0:79]        buf_q, buf_d;
    logic [3:0]         len_q, len_d;
    logic [3:0]         issue_cnt_q, issue_cnt_d;
    logic [3:0]         cap_cnt_q, cap_cnt_d;
    logic               err_q, err_d;
    logic               rd_q, rd_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    // slot_*: a byte was issued this cycle (even if its read was suppressed);
    // cap_*: that slot's data is on imem_rdata this cycle.
    logic               slot_q, slot_d;
    logic               slot_oob_q, slot_oob_d;
    logic               cap_pend_q, cap_pend_d;
    logic               cap_oob_q, cap_oob_d;

    logic [3:0]         issue_idx;
    logic [IMEM_AW-1:0] issue_addr;
    logic               issue_oob;
    logic               do_issue;
    logic               first_cap;
    logic [7:0]         cap_byte;
    logic [3:0]         cur_len;

    // A new load always issues byte 0 from the incoming PC.
    assign issue_idx = (state_q == ST_IDLE) ? 4'd0 : issue_cnt_q;

`ifdef IMEM_BOUND_CHECK_EN
    logic [63:0] issue_full;
    assign issue_full = ((state_q == ST_IDLE) ? req_pc : pc_q) + 64'(issue_idx);
    assign issue_addr = issue_full[IMEM_AW-1:0];
    assign issue_oob  = (issue_full >= 64'(IMEM_SIZE));
`else
    assign issue_addr = ((state_q == ST_IDLE) ? req_pc[IMEM_AW-1:0] : pc_q[IMEM_AW-1:0])
                        + IMEM_AW'(issue_idx);
    assign issue_oob  = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        err_d       = err_q;
        addr_d      = addr_q;
        rd_d        = 1'b0;
        slot_d      = 1'b0;
        slot_oob_d  = 1'b0;
        cap_pend_d  = 1'b0;
        cap_oob_d   = 1'b0;
        do_issue    = 1'b0;

        cap_byte  = cap_oob_q ? 8'h00 : imem_rdata;
        first_cap = cap_pend_q && (cap_cnt_q == 4'd0);
        // The length is usable on the very edge that captures byte 0.
        cur_len   = first_cap ? decode_len(cap_byte[7:4]) : len_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d   = ST_LOAD;
                    pc_d      = req_pc;
                    buf_d     = '0;
                    len_d     = 4'd0;
                    cap_cnt_d = 4'd0;
                    err_d     = 1'b0;
                    do_issue  = 1'b1;
                end
            end
            ST_LOAD: begin
                cap_pend_d = slot_q;
                cap_oob_d  = slot_oob_q;
                if (cap_pend_q && (first_cap || (cap_cnt_q < len_q))) begin
                    buf_d[{cap_cnt_q, 3'b000} +: 8] = cap_byte;
                    cap_cnt_d = cap_cnt_q + 4'd1;
                    len_d     = cur_len;
                    if (cap_oob_q) begin
                        err_d = 1'b1;
                    end
                    if (cap_cnt_q + 4'd1 == cur_len) begin
                        state_d = ST_DONE;
                    end
                end
                // Byte 0 still unknown: keep issuing blindly (byte 1 is always fetched).
                if ((state_d == ST_LOAD) && ((cap_cnt_d == 4'd0) || (issue_cnt_q < cur_len))) begin
                    do_issue = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_issue) begin
            slot_d      = 1'b1;
            slot_oob_d  = issue_oob;
            rd_d        = !issue_oob;
            addr_d      = issue_addr;
            issue_cnt_d = issue_idx + 4'd1;
        end

        // Flush wins over every other transition; in-flight data is dropped.
        if (flush) begin
            state_d    = ST_IDLE;
            rd_d       = 1'b0;
            slot_d     = 1'b0;
            cap_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            // NOTE: the instruction buffer is a plain register vector and is visible, so it is reset.
            buf_q       <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            slot_q      <= 1'b0;
            slot_oob_q  <= 1'b0;
            cap_pend_q  <= 1'b0;
            cap_oob_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_q       <= buf_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            slot_q      <= slot_d;
            slot_oob_q  <= slot_oob_d;
            cap_pend_q  <= cap_pend_d;
            cap_oob_q   <= cap_oob_d;
        end
    end

    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign imem_rd   = rd_q;
    assign imem_addr = addr_q;
    assign instruct  = buf_q;
    assign out_pc    = pc_q;
    assign out_len   = len_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Randomized self-checking bench for imem_fetch_buffer against a transaction-level
// model: length table lookup, expected byte image, read-address list and latency.
module tb_imem_fetch_buffer;

    localparam int AW   = 10;
    localparam int SIZE = 1024;
`ifdef IMEM_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_pc;
    logic          imem_rd;
    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [0:79]   instruct;
    logic [63:0]   out_pc;
    logic [3:0]    out_len;
    logic          mem_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imem_fetch_buffer #(.IMEM_AW(AW), .IMEM_SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instruct   (instruct),
        .out_pc     (out_pc),
        .out_len    (out_len),
        .mem_err    (mem_err)
    );

    // Synchronous memory: data for a read appears the cycle after the strobe, junk otherwise.
    logic [7:0] mem [0:SIZE-1];
    always @(posedge clk) begin
        imem_rdata <= imem_rd ? mem[imem_addr] : 8'($urandom);
    end

    logic [AW-1:0] rd_log[$];
    int bad_rd = 0;
    always @(posedge clk) begin
        if (imem_rd) begin
            rd_log.push_back(imem_addr);
            if (out_valid || req_ready) bad_rd++;
        end
    end

    // Instruction length per icode, straight from the ISA encoding table.
    int len_table [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit addr_oob(input logic [63:0] a);
        return BOUND && (a >= 64'(SIZE));
    endfunction

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [AW-1:0] idx;
        idx = a[AW-1:0];
        return addr_oob(a) ? 8'h00 : mem[idx];
    endfunction

    task automatic randomize_mem();
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
    endtask

    task automatic run_txn(input logic [63:0] pc, input int hold, input string name);
        logic [79:0]   exp_instr;
        logic [7:0]    b;
        logic [63:0]   a;
        logic [AW-1:0] exp_rd[$];
        bit            exp_err;
        int            len, n_iss, edges;

        exp_instr = '0;
        exp_err   = 1'b0;
        b         = mem_byte(pc);
        len       = len_table[b[7:4]];
        for (int k = 0; k < len; k++) begin
            a = pc + 64'(k);
            exp_instr[79-8*k -: 8] = mem_byte(a);
            if (addr_oob(a)) exp_err = 1'b1;
        end
        n_iss = (len < 2) ? 2 : len;
        for (int k = 0; k < n_iss; k++) begin
            a = pc + 64'(k);
            if (!addr_oob(a)) exp_rd.push_back(a[AW-1:0]);
        end

        @(negedge clk);
        check({name, " req_ready idle"}, 80'(req_ready), 80'(1));
        rd_log.delete();
        req_valid = 1'b1;
        req_pc    = pc;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_pc    = {$urandom, $urandom};
        edges     = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({name, " latency"}, 80'(edges), 80'(len + 1));
        check({name, " instruct"}, instruct, exp_instr);
        check({name, " out_len"}, 80'(out_len), 80'(len));
        check({name, " out_pc"}, 80'(out_pc), 80'(pc));
        check({name, " mem_err"}, 80'(mem_err), 80'(exp_err));
        check({name, " read count"}, 80'(rd_log.size()), 80'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size(); i++) begin
            check({name, " read addr"}, (i < rd_log.size()) ? 80'(rd_log[i]) : '1, 80'(exp_rd[i]));
        end

        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, " hold out_valid"}, 80'(out_valid), 80'(1));
            check({name, " hold instruct"}, instruct, exp_instr);
            check({name, " hold out_len"}, 80'(out_len), 80'(len));
            check({name, " hold out_pc"}, 80'(out_pc), 80'(pc));
            check({name, " hold req_ready"}, 80'(req_ready), 80'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " released out_valid"}, 80'(out_valid), 80'(0));
        check({name, " released req_ready"}, 80'(req_ready), 80'(1));
        check({name, " final read count"}, 80'(rd_log.size()), 80'(exp_rd.size()));
    endtask

    initial begin
        logic [63:0] pc;
        int          sel;

        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        out_ready = 1'b0;
        randomize_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 80'(req_ready), 80'(0));
        check("reset out_valid", 80'(out_valid), 80'(0));
        check("reset imem_rd", 80'(imem_rd), 80'(0));
        check("reset instruct", instruct, 80'(0));
        rst_n = 1'b1;

        // nop at address 0
        mem[0] = 8'h10;
        run_txn(64'd0, 0, "nop pc0");

        // irmovq at 4 with backpressure
        mem[4] = 8'h30; mem[5] = 8'hF3; mem[6] = 8'h0A;
        for (int i = 7; i <= 13; i++) mem[i] = 8'h00;
        run_txn(64'd4, 5, "irmovq pc4");

        mem[8] = 8'hC0;
        run_txn(64'd8, 1, "iaddq-len1 pc8");

        // flush during a jxx load, then a clean nop
        mem[20] = 8'h70;
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = 64'd20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("flush pre imem_rd", 80'(imem_rd), 80'(1));
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush out_valid", 80'(out_valid), 80'(0));
        check("flush imem_rd", 80'(imem_rd), 80'(0));
        check("flush req_ready", 80'(req_ready), 80'(1));
        repeat (3) @(posedge clk);
        mem[0] = 8'h10;
        run_txn(64'd0, 0, "post-flush nop");

        // reset in the middle of a length-10 load
        mem[4] = 8'h30;
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = 64'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midload rst out_valid", 80'(out_valid), 80'(0));
        check("midload rst imem_rd", 80'(imem_rd), 80'(0));
        check("midload rst imem_addr", 80'(imem_addr), 80'(0));
        check("midload rst instruct", instruct, 80'(0));
        check("midload rst out_pc", 80'(out_pc), 80'(0));
        check("midload rst out_len", 80'(out_len), 80'(0));
        check("midload rst mem_err", 80'(mem_err), 80'(0));
        check("midload rst req_ready", 80'(req_ready), 80'(0));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post rst req_ready", 80'(req_ready), 80'(1));

        // 64-bit wrap of the byte address
        mem[1020] = 8'h30;
        run_txn(64'hFFFF_FFFF_FFFF_FFFC, 0, "wrap pc");
        mem[1023] = 8'h30;
        run_txn(64'd1023, 0, "top byte pc1023");
        run_txn(64'd2000, 0, "pc2000");

        for (int t = 0; t < 24; t++) begin
            randomize_mem();
            sel = $urandom_range(0, 3);
            case (sel)
                0:       pc = 64'($urandom_range(SIZE - 12, SIZE - 1));
                1:       pc = {$urandom, $urandom};
                default: pc = 64'($urandom_range(0, SIZE - 1));
            endcase
            run_txn(pc, $urandom_range(0, 3), "random");
        end

        check("no reads in idle/done", 80'(bad_rd), 80'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_buffer.md
# imem_fetch_buffer

- Sequential instruction-byte loader that sits directly upstream of the SEQ fetch stage.
- Accepts a PC over a valid/ready handshake and reads instruction memory one byte per cycle.
- Stops reading once the instruction length is known from the first byte's icode.
- Presents the assembled 80-bit `instruct` word, zero-padded, to fetch with a valid/ready handshake.

## Interface
Parameters:
- `IMEM_AW`, 10, instruction memory byte-address width.
- `IMEM_SIZE`, 1024, number of valid instruction memory bytes (≤ 2^IMEM_AW).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  abort current load; return to idle.
- `req_valid`  in  1  `req_pc` is valid.
- `req_ready`  out  1  block can accept a request.
- `req_pc`  in  64  byte address of the instruction.
- `imem_rd`  out  1  memory read strobe (registered).
- `imem_addr`  out  IMEM_AW  memory byte address (registered).
- `imem_rdata`  in  8  read data, valid the cycle after `imem_rd`.
- `out_valid`  out  1  `instruct` / `out_pc` / `out_len` / `mem_err` are valid.
- `out_ready`  in  1  fetch consumes the output.
- `instruct`  out  [0:79]  byte k of the instruction on bits [8k:8k+7].
- `out_pc`  out  64  PC of the presented instruction.
- `out_len`  out  4  instruction length in bytes: 1, 2, 9 or 10.
- `mem_err`  out  1  an instruction byte address was ≥ IMEM_SIZE.

## Operation
States:
- IDLE: `req_ready` = 1 when `rst_n` = 1.
- LOAD: issuing reads and capturing returned bytes.
- DONE: `out_valid` = 1.

Transitions:
- IDLE → LOAD on `req_valid & req_ready`.
  - Latch `req_pc`, clear the byte buffer to zero.
  - Clear the issue counter, the capture counter and the sticky error.
- In LOAD, byte k is issued at address `pc+k`, one per cycle, starting the cycle after the handshake.
- Length decode, applied to the captured byte 0 icode (bits [0:3]):
  - 0, 1, 9, C–F → 1
  - 2, 6, A, B → 2
  - 7, 8 → 9
  - 3, 4, 5 → 10
- Until byte 0 is captured, issuing continues; byte 1 is therefore always issued.
- After byte 0 is captured, issue only while issued count < length.
- Surplus returned data (e.g. byte 1 for length 1) is discarded and never written into `instruct`.
- LOAD → DONE at the edge capturing byte length-1.
- DONE → IDLE on `out_ready`.
  - No new request is accepted in the same cycle.
  - Outputs hold while `out_ready` = 0.
- Unloaded bytes of `instruct` are 0x00.
- The 64-bit address sum wraps modulo 2^64.
- `flush` (priority below reset, above everything else): next edge → IDLE, `out_valid` = 0, `imem_rd` = 0. Read data returning afterwards is ignored.

Reset (`rst_n` = 0 at an edge):
- State = IDLE.
- `imem_rd`, `imem_addr`, `out_valid`, `instruct`, `out_pc`, `out_len`, `mem_err` all 0.
- `req_ready` = 0 while `rst_n` is low.
- Reset mid-LOAD or mid-DONE discards everything.

## Timing
- Handshake at edge E0; byte k is issued in cycle k+1 and captured at edge E(k+2).
- `out_valid` rises after edge E(L+1), where L = length:
  - length 1 → 2 edges, 2 reads
  - length 2 → 3 edges, 2 reads
  - length 9 → 10 edges, 9 reads
  - length 10 → 11 edges, 10 reads
- Minimum request-to-request spacing is L+3 cycles with `out_ready` held at 1.
- `imem_rd` never asserts in IDLE or DONE.

## Configuration
- `IMEM_BOUND_CHECK_EN` defined:
  - An issue address ≥ IMEM_SIZE (full 64-bit compare) suppresses `imem_rd` for that slot.
  - The corresponding byte is captured as 0x00 and sticky `mem_err` is set.
  - An out-of-range byte 0 therefore decodes as icode 0 (length 1).
- `IMEM_BOUND_CHECK_EN` undefined:
  - `imem_addr` = low IMEM_AW bits of the address (aliasing).
  - `mem_err` tied 0.

## Test plan
- mem[0]=0x10, request pc=0 → `out_valid` 2 edges after handshake; `instruct`=0x10 followed by 9 zero bytes; `out_len`=1; exactly 2 `imem_rd` pulses.
- mem[4..13]=30 F3 0A 00 00 00 00 00 00 00, pc=4 → `instruct`=0x30F30A00000000000000; `out_len`=10; `out_pc`=4; `out_valid` after 11 edges; 10 reads at addresses 4–13.
- Backpressure: `out_ready` low for 5 cycles after `out_valid` → `instruct` / `out_len` / `out_pc` stable, `req_ready`=0; one cycle after `out_ready`=1, `req_ready`=1.
- mem[20]=0x70 (jxx), `flush` at cycle 4 of LOAD → next edge `out_valid`=0, `imem_rd`=0, `req_ready`=1; a following request at pc=0 (nop) completes correctly with no stale bytes.
- mem[8]=0xC0, pc=8 → `out_len`=1, `instruct`=0xC0 followed by zeros; `rst_n` low during a length-10 LOAD → all outputs 0 at the next edge.
- `IMEM_BOUND_CHECK_EN`, IMEM_SIZE=1024, mem[1023]=0x30, pc=1023 → 1 read only, bytes 1–9 = 0x00, `mem_err`=1, `out_len`=10.
- `IMEM_BOUND_CHECK_EN`, pc=2000 → 0 reads, `instruct`=0, `mem_err`=1, `out_len`=1.
